multi_sensor_counter: RTL and testbench

- Multi-channel, parametrised successor to the single-channel sensor counter.
- Each of CH channels counts clk cycles while its load (enable) is high, and freezes on stop.
- Raises a one-cycle carry on reaching its own terminal value, in either one-shot or auto-reload mode.
- Sits between the sensor front-end control and the sensor controller FSM; gives per-channel timing and sample-period generation.

---
 rtl/multi_sensor_counter_if.sv | 25 ++
 rtl/multi_sensor_counter.sv | 135 +++++++++++++
 tb/tb_multi_sensor_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multi_sensor_counter_if.sv
// Bundle of per-channel control inputs and status outputs for multi_sensor_counter.
interface multi_sensor_counter_if #(
  parameter int NUM = 16,
  parameter int CH  = 4
);
  logic [CH-1:0]     load;
  logic [CH-1:0]     stop;
  logic [CH-1:0]     mode;
  logic [CH*NUM-1:0] load_value;
  logic [CH-1:0]     clr_done;
  logic [CH*NUM-1:0] count;
  logic [CH-1:0]     carry;
  logic [CH-1:0]     done;
  logic [CH*8-1:0]   ovf_cnt;

  modport master (
    output load, stop, mode, load_value, clr_done,
    input  count, carry, done, ovf_cnt
  );

  modport slave (
    input  load, stop, mode, load_value, clr_done,
    output count, carry, done, ovf_cnt
  );
endinterface

// File: rtl/multi_sensor_counter.sv
// CH independent terminal counters with one-shot / auto-reload modes.
// Optional per-channel saturating carry counter enabled by SENSOR_OVF_CNT_EN.
module msc_channel #(
  parameter int NUM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           stop,
  input  logic           mode,
  input  logic [NUM-1:0] load_value,
  input  logic           clr_done,
  output logic [NUM-1:0] count,
  output logic           carry,
  output logic           done,
  output logic [7:0]     ovf_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t         state, state_n;
  logic [NUM-1:0] count_n;
  logic           carry_n;
  logic           done_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      carry <= carry_n;
      done  <= done_set | (done & ~clr_done);
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    carry_n  = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        if (load && !stop) state_n = RUN;
      end
      RUN: begin
        if (stop) begin
          state_n = HOLD;
        end else if (!load) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count >= load_value) begin
          // compare is >= so a lowered terminal value still fires; count never wraps
          carry_n = 1'b1;
          if (mode) begin
            count_n = '0;
          end else begin
            state_n  = DONE;
            done_set = 1'b1;
          end
        end else begin
          count_n = count + 1'b1;
        end
      end
      HOLD: begin
        if (!stop) begin
          if (load) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
            count_n = '0;
          end
        end
      end
      DONE: begin
        if (!load) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

`ifdef SENSOR_OVF_CNT_EN
  logic [7:0] ovf_q;

  // updates on the same edge the carry pulse is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (carry_n) begin
      if (clr_done)           ovf_q <= 8'd1;
      else if (ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end else if (clr_done) begin
      ovf_q <= '0;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif
endmodule

module multi_sensor_counter #(
  parameter int NUM = 16,
  parameter int CH  = 4
) (
  input logic                   clk,
  input logic                   rst,
  multi_sensor_counter_if.slave bus
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    msc_channel #(.NUM(NUM)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load       (bus.load[i]),
      .stop       (bus.stop[i]),
      .mode       (bus.mode[i]),
      .load_value (bus.load_value[i*NUM +: NUM]),
      .clr_done   (bus.clr_done[i]),
      .count      (bus.count[i*NUM +: NUM]),
      .carry      (bus.carry[i]),
      .done       (bus.done[i]),
      .ovf_cnt    (bus.ovf_cnt[i*8 +: 8])
    );
  end
endmodule

// File: tb/tb_multi_sensor_counter.sv
// Table-driven bench for multi_sensor_counter (NUM=8, CH=2) with a scoreboard queue.
module tb_multi_sensor_counter;
  localparam int NUM = 8;
  localparam int CH  = 2;
`ifdef SENSOR_OVF_CNT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [1:0] load, stop, mode, clr;
    logic [7:0] lv0, lv1;
    logic [7:0] c0, c1;
    logic [1:0] cy, dn;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic [1:0]  cy, dn;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_sensor_counter_if #(.NUM(NUM), .CH(CH)) bus ();
  multi_sensor_counter #(.NUM(NUM), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input logic r, input logic [1:0] ld, st, md, cl,
                              input logic [7:0] l0, l1, c0, c1, input logic [1:0] cy, dn);
    vec_t v;
    v.rst = r; v.load = ld; v.stop = st; v.mode = md; v.clr = cl;
    v.lv0 = l0; v.lv1 = l1; v.c0 = c0; v.c1 = c1; v.cy = cy; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst            = v.rst;
    bus.load       = v.load;
    bus.stop       = v.stop;
    bus.mode       = v.mode;
    bus.clr_done   = v.clr;
    bus.load_value = {v.lv1, v.lv0};
    e.cnt = {v.c1, v.c0}; e.cy = v.cy; e.dn = v.dn; e.idx = idx;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("count", e.idx, 32'(bus.count), 32'(e.cnt));
    chk("carry", e.idx, 32'(bus.carry), 32'(e.cy));
    chk("done",  e.idx, 32'(bus.done),  32'(e.dn));
  endtask

  initial begin
    rst = 1'b1;
    bus.load = '0; bus.stop = '0; bus.mode = '0; bus.clr_done = '0; bus.load_value = '0;

    // reset state
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    // ch0 auto-reload lv=4, ch1 one-shot lv=3, load high 20 cycles
    for (int k = 1; k <= 20; k++)
      add(0, 2'b11, 2'b00, 2'b01, 2'b00, 8'd4, 8'd3,
          (k == 1) ? 8'd0 : 8'((k - 1) % 5),
          (k <= 4) ? 8'(k - 1) : 8'd3,
          {(k == 5), (k >= 6 && (k - 1) % 5 == 0)},
          {(k >= 5), 1'b0});
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 8'd4, 8'd3, 8'd0, 8'd0, 2'b00, 2'b10);
    add(0, 2'b00, 2'b00, 2'b01, 2'b10, 8'd4, 8'd3, 8'd0, 8'd0, 2'b00, 2'b00);
    // stop freezes ch0 at 2, resume, then stop with load low -> HOLD -> IDLE
    for (int k = 0; k < 3; k++)
      add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'(k), 8'd0, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++)
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 8'd4, 8'd0, 8'd2, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd2, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd3, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd4, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd1, 8'd0, 2'b00, 2'b00);
    add(0, 2'b00, 2'b01, 2'b01, 2'b00, 8'd4, 8'd0, 8'd1, 8'd0, 2'b00, 2'b00);
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    // load_value=0 on both; ch1 clr_done held high: set wins, then clears
    add(0, 2'b11, 2'b00, 2'b01, 2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b10);
    add(0, 2'b11, 2'b00, 2'b01, 2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    // ch0 one-shot lv=10, lowered to 2 at count 5; stop ignored in DONE
    for (int k = 0; k < 6; k++)
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd10, 8'd0, 8'(k), 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd2, 8'd0, 8'd5, 8'd0, 2'b01, 2'b01);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 8'd5, 8'd0, 2'b00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd2, 8'd0, 8'd0, 8'd0, 2'b00, 2'b01);
    // reset mid-count with load still high
    for (int k = 0; k < 4; k++)
      add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'(k), 8'd0, 2'b00, 2'b01);
    add(1, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd1, 8'd0, 2'b00, 2'b00);
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // carry-event counter: lv=0 auto-reload gives a carry every cycle
    @(negedge clk);
    rst = 1'b1; bus.load = '0; bus.stop = '0; bus.clr_done = '0;
    @(posedge clk); #1;
    chk("ovf_rst", 0, 32'(bus.ovf_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.mode = 2'b01; bus.load_value = '0; bus.load = 2'b01;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 10 || k == 255 || k == 256 || k == 300)
        chk("ovf_ch0", k, 32'(bus.ovf_cnt[7:0]),
            OVF ? 32'((k < 2) ? 0 : ((k - 1 > 255) ? 255 : k - 1)) : 32'd0);
      if (k == 150) chk("carry_lv0", k, 32'(bus.carry), 32'd1);
    end
    @(negedge clk);
    bus.clr_done = 2'b01;
    @(posedge clk); #1;
    chk("ovf_clr_inc", 0, 32'(bus.ovf_cnt[7:0]), OVF ? 32'd1 : 32'd0);
    chk("ovf_ch1", 0, 32'(bus.ovf_cnt[15:8]), 32'd0);
    @(negedge clk);
    bus.clr_done = '0; bus.load = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
